// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined lookahead adder/subtractor.
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int GROUP_W = 4;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational slice adder: 4-bit lookahead groups chained by group generate/propagate.
module cla_slice
  import pipe_addsub_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int NG = SLICE / GROUP_W;

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;

  assign g = a & b;
  assign p = a ^ b;

  // Carries inside a group are expanded from the group carry-in; groups chain via G/P.
  always_comb begin
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    c[0]  = cin;
    for (int j = 0; j < NG; j++) begin
      c[j*GROUP_W+1] = g[j*GROUP_W] | (p[j*GROUP_W] & c[j*GROUP_W]);
      c[j*GROUP_W+2] = g[j*GROUP_W+1] | (p[j*GROUP_W+1] & g[j*GROUP_W])
                     | (p[j*GROUP_W+1] & p[j*GROUP_W] & c[j*GROUP_W]);
      c[j*GROUP_W+3] = g[j*GROUP_W+2] | (p[j*GROUP_W+2] & g[j*GROUP_W+1])
                     | (p[j*GROUP_W+2] & p[j*GROUP_W+1] & g[j*GROUP_W])
                     | (p[j*GROUP_W+2] & p[j*GROUP_W+1] & p[j*GROUP_W] & c[j*GROUP_W]);
      grp_g[j] = g[j*GROUP_W+3] | (p[j*GROUP_W+3] & g[j*GROUP_W+2])
               | (p[j*GROUP_W+3] & p[j*GROUP_W+2] & g[j*GROUP_W+1])
               | (p[j*GROUP_W+3] & p[j*GROUP_W+2] & p[j*GROUP_W+1] & g[j*GROUP_W]);
      grp_p[j] = &p[j*GROUP_W +: GROUP_W];
      c[j*GROUP_W+GROUP_W] = grp_g[j] | (grp_p[j] & c[j*GROUP_W]);
    end
  end

  assign sum      = p ^ c[SLICE-1:0];
  assign cout     = c[SLICE];
  assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Optional PIPE_ADDSUB_FLUSH_EN adds a flush input that kills every in-flight beat.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
`ifdef PIPE_ADDSUB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  logic             adv;
  logic             kill;
  logic             accept;
  logic [WIDTH-1:0] b_mod;
  logic             cin0;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

`ifdef PIPE_ADDSUB_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~kill;
  assign accept   = in_valid & in_ready;
  assign b_mod    = in_b ^ {WIDTH{in_op}};
  assign cin0     = (in_op == OP_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM  = WIDTH - k*SLICE;
    localparam int DONE = (k+1)*SLICE;

    logic [REM-1:0]   a_cur;
    logic [REM-1:0]   b_cur;
    logic             c_cur;
    logic             v_cur;
    logic [SLICE-1:0] s_slice;
    logic             c_out;
    logic [DONE-1:0]  s_next;
    logic [DONE-1:0]  s_q;
    logic             v_q;

    if (k == 0) begin : g_src
      assign a_cur  = in_a;
      assign b_cur  = b_mod;
      assign c_cur  = cin0;
      assign v_cur  = accept;
      assign s_next = s_slice;
    end else begin : g_src
      assign a_cur  = g_stage[k-1].g_fwd.a_q;
      assign b_cur  = g_stage[k-1].g_fwd.b_q;
      assign c_cur  = g_stage[k-1].g_fwd.c_q;
      assign v_cur  = g_stage[k-1].v_q;
      assign s_next = {s_slice, g_stage[k-1].s_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        v_q <= 1'b0;
      end else if (kill) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_cur;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s_q <= '0;
      end else if (adv) begin
        s_q <= s_next;
      end
    end

    if (k < STAGES-1) begin : g_fwd
      logic [REM-SLICE-1:0] a_q;
      logic [REM-SLICE-1:0] b_q;
      logic                 c_q;
      logic                 c_msb_unused;

      cla_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_cur[SLICE-1:0]),
        .b        (b_cur[SLICE-1:0]),
        .cin      (c_cur),
        .sum      (s_slice),
        .cout     (c_out),
        .c_msb_in (c_msb_unused)
      );

      // Upper operand bits ride along until their slice is reached.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_cur[REM-1:SLICE];
          b_q <= b_cur[REM-1:SLICE];
          c_q <= c_out;
        end
      end
    end else begin : g_last
      logic c_msb;

      cla_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_cur),
        .b        (b_cur),
        .cin      (c_cur),
        .sum      (s_slice),
        .cout     (c_out),
        .c_msb_in (c_msb)
      );

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          cout_q <= c_out;
          ovf_q  <= c_msb ^ c_out;
          zero_q <= ~|s_next;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_sum   = g_stage[STAGES-1].s_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub; runs the flush scenario with STAGES=4
// when PIPE_ADDSUB_FLUSH_EN is defined.
module tb_pipe_addsub;
  import pipe_addsub_pkg::*;

`ifdef PIPE_ADDSUB_FLUSH_EN
  localparam int STG = 4;
`else
  localparam int STG = 2;
`endif
  localparam int W = 32;

  typedef logic [34:0] res_t;

  logic         clk;
  logic         resetn;
`ifdef PIPE_ADDSUB_FLUSH_EN
  logic         flush;
`endif
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  res_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   got    = 0;

  pipe_addsub #(.WIDTH(W), .STAGES(STG)) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef PIPE_ADDSUB_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t res(input logic c, input logic o, input logic z, input logic [W-1:0] s);
    return {c, o, z, s};
  endfunction

  function automatic res_t curOut();
    return {out_cout, out_ovf, out_zero, out_sum};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one beat, holds it until accepted, then records its expected result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic op, input res_t exp, output int waits);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_op    = op;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) checkOutput("accept timeout", {63'd0, in_ready}, 64'd1);
    else expq.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic measureLatency(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every transferred result must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      got++;
      if (expq.size() == 0) checkOutput("unexpected out_valid", {63'd0, out_valid}, 64'd0);
      else checkOutput($sformatf("result %0d", got), {29'd0, curOut()}, {29'd0, expq.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int wsum;
    int lat;
    int g0;

    resetn    = 1'b0;
`ifdef PIPE_ADDSUB_FLUSH_EN
    flush     = 1'b0;
`endif
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_op     = OP_ADD;
    out_ready = 1'b1;

    #12;
    checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset outputs", {29'd0, curOut()}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    checkOutput("in_ready after reset", {63'd0, in_ready}, 64'd1);

    $display("[TB] carry across slice boundary");
    applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, OP_ADD, res(0, 0, 0, 32'h00010000), w);
    measureLatency(lat);
    checkOutput("latency", lat, STG);

    $display("[TB] overflow and wrap cases");
    applyStimulus(32'h80000000, 32'h00000001, 1'b0, OP_SUB, res(1, 1, 0, 32'h7FFFFFFF), w);
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, OP_ADD, res(0, 1, 0, 32'h80000000), w);
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, OP_ADD, res(1, 0, 1, 32'h00000000), w);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, OP_ADD, res(1, 0, 1, 32'h00000000), w);
    applyStimulus(32'h00000005, 32'h00000003, 1'b1, OP_SUB, res(1, 0, 0, 32'h00000002), w);
    repeat (STG + 2) @(posedge clk);
    #1;

    $display("[TB] back-to-back beats");
    g0   = got;
    wsum = 0;
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, OP_ADD, res(0, 0, 0, 32'h23456789), w); wsum += w;
    applyStimulus(32'h00000005, 32'h00000007, 1'b0, OP_SUB, res(0, 0, 0, 32'hFFFFFFFE), w); wsum += w;
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, OP_ADD, res(1, 1, 1, 32'h00000000), w); wsum += w;
    applyStimulus(32'h00000003, 32'h00000003, 1'b1, OP_SUB, res(1, 0, 1, 32'h00000000), w); wsum += w;
    applyStimulus(32'hFFFF0000, 32'h0000FFFF, 1'b0, OP_ADD, res(0, 0, 0, 32'hFFFFFFFF), w); wsum += w;
    applyStimulus(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, OP_SUB, res(0, 1, 0, 32'h80000000), w); wsum += w;
    applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, OP_ADD, res(1, 0, 1, 32'h00000000), w); wsum += w;
    applyStimulus(32'h00000001, 32'h00000002, 1'b1, OP_ADD, res(0, 0, 0, 32'h00000004), w); wsum += w;
    checkOutput("back-to-back input stalls", wsum, 0);
    repeat (STG + 2) @(posedge clk);
    #1;
    checkOutput("back-to-back result count", got - g0, 8);

    $display("[TB] output stall");
    g0 = got;
    fork
      begin
        applyStimulus(32'h00000001, 32'h00000001, 1'b0, OP_ADD, res(0, 0, 0, 32'h00000002), w);
        applyStimulus(32'h000000FF, 32'h00000001, 1'b0, OP_ADD, res(0, 0, 0, 32'h00000100), w);
        applyStimulus(32'h00000100, 32'h00000001, 1'b0, OP_SUB, res(1, 0, 0, 32'h000000FF), w);
        applyStimulus(32'h0FFFFFFF, 32'h0FFFFFFF, 1'b0, OP_ADD, res(0, 0, 0, 32'h1FFFFFFE), w);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
          n++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput($sformatf("stall in_ready %0d", i), {63'd0, in_ready}, 64'd0);
          checkOutput($sformatf("stall out_valid %0d", i), {63'd0, out_valid}, 64'd1);
          checkOutput($sformatf("stall held output %0d", i), {29'd0, curOut()},
                      {29'd0, res(0, 0, 0, 32'h00000100)});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (STG + 3) @(posedge clk);
    #1;
    checkOutput("stall result count", got - g0, 4);

    $display("[TB] asynchronous reset with beats in flight");
    applyStimulus(32'h00000010, 32'h00000020, 1'b0, OP_ADD, res(0, 0, 0, 32'h00000030), w);
    applyStimulus(32'h00000040, 32'h00000050, 1'b0, OP_ADD, res(0, 0, 0, 32'h00000090), w);
    repeat (STG - 2) @(posedge clk);
    #2;
    checkOutput("pre-reset out_valid", {63'd0, out_valid}, 64'd1);
    g0     = got;
    resetn = 1'b0;
    #1;
    checkOutput("async reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async reset outputs", {29'd0, curOut()}, 64'd0);
    expq.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (STG + 4) @(posedge clk);
    #1;
    checkOutput("no stale result after reset", got - g0, 0);

`ifdef PIPE_ADDSUB_FLUSH_EN
    $display("[TB] flush with beats in flight");
    applyStimulus(32'h00000001, 32'h00000002, 1'b0, OP_ADD, res(0, 0, 0, 32'h00000003), w);
    applyStimulus(32'h00000003, 32'h00000004, 1'b0, OP_ADD, res(0, 0, 0, 32'h00000007), w);
    applyStimulus(32'h00000005, 32'h00000006, 1'b0, OP_ADD, res(0, 0, 0, 32'h0000000B), w);
    g0       = got;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'h00000099;
    in_b     = 32'h00000001;
    in_op    = OP_ADD;
    #1;
    checkOutput("flush in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    checkOutput("flush out_valid", {63'd0, out_valid}, 64'd0);
    repeat (STG + 2) @(posedge clk);
    #1;
    checkOutput("no result after flush", got - g0, 0);
    applyStimulus(32'h0000FFFF, 32'hFFFF0001, 1'b0, OP_ADD, res(1, 0, 1, 32'h00000000), w);
    measureLatency(lat);
    checkOutput("latency after flush", lat, STG);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("result after flush count", got - g0, 1);
`endif

    checkOutput("scoreboard drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
